noc_send_arbiter: RTL

//  Shares the single NoC send port (8-bit dest addr + 32-bit payload) between NUM_REQ

---
 rtl/noc_send_arbiter_pkg.sv | 25 ++
 rtl/noc_send_arbiter_if.sv | 32 +++
 rtl/noc_send_arbiter_rr_arbiter.sv | 36 +++
 rtl/noc_send_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/noc_send_arbiter_pkg.sv
// Package shared by the NoC send arbiter files.
//   ADDR_W / DATA_W : NoC destination address and payload widths
//   CNT_W           : width of the accepted-packet counter
//   TMR_W           : width of the SEND/GAP cycle timer
//   state_t         : arbiter FSM states
//   wrap_inc        : round-robin pointer increment with wrap
package noc_send_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int TMR_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Index following idx in a ring of n requesters.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/noc_send_arbiter_if.sv
// Bundle of requester-side and NoC-side handshake signals of the send arbiter.
//   req_valid/req_addr/req_data : packets offered by NUM_REQ requesters
//   req_ready                   : one-hot accept pulse back to the requesters
//   send_valid/addr/data        : packet presented to the NoC injection port
//   send_ready                  : NoC accepts the presented packet
// Modports: slave = arbiter view, master = requesters + NoC view.
interface noc_send_arbiter_if
  import noc_send_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      send_valid;
  logic [ADDR_W-1:0]         send_addr;
  logic [DATA_W-1:0]         send_data;
  logic                      send_ready;

  modport slave (
    input  req_valid, req_addr, req_data, send_ready,
    output req_ready, send_valid, send_addr, send_data
  );

  modport master (
    output req_valid, req_addr, req_data, send_ready,
    input  req_ready, send_valid, send_addr, send_data
  );

endinterface

// File: rtl/noc_send_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req         : request vector
//   ptr         : highest-priority index this round
//   grant       : one-hot winner (zero when no request)
//   grant_idx   : binary index of the winner
//   grant_valid : at least one request present
module noc_send_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  always_comb begin
    logic [IDX_W:0] cand;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    // Walk ptr, ptr+1, ... with wrap; the first requester seen wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!grant_valid && req[cand[IDX_W-1:0]]) begin
        grant[cand[IDX_W-1:0]] = 1'b1;
        grant_idx              = cand[IDX_W-1:0];
        grant_valid            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_send_arbiter.sv
// Shares one NoC send port between NUM_REQ requesters.
// Round-robin grant in IDLE, one packet held in SEND until the NoC accepts it
// or TIMEOUT cycles pass (dropped), then GAP_CYCLES idle cycles.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : requester and NoC handshakes (slave modport)
//   grant_id   : requester owning the current/last packet
//   drop_pulse : one-cycle pulse after a timed-out packet
//   pkt_count  : packets accepted by the NoC, wrapping
module noc_send_arbiter
  import noc_send_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  noc_send_arbiter_if.slave          bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       drop_pulse,
  output logic [CNT_W-1:0]           pkt_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // Last timer value before leaving SEND / GAP (timer starts at 0).
  localparam logic [TMR_W-1:0] SEND_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;
  logic               drop_pulse_q, drop_pulse_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  noc_send_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req         (bus.req_valid),
    .ptr         (ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_id_d   = grant_id_q;
    addr_d       = addr_q;
    data_d       = data_q;
    pkt_count_d  = pkt_count_q;
    drop_pulse_d = 1'b0;
    timer_d      = timer_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          addr_d     = addr_arr[arb_idx];
          data_d     = data_arr[arb_idx];
          grant_id_d = arb_idx;
          ptr_d      = IDX_W'(wrap_inc(int'(arb_idx), NUM_REQ));
          timer_d    = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        // Acceptance takes priority over the timeout in the same cycle.
        if (bus.send_ready || (TIMEOUT != 0 && timer_q == SEND_LAST)) begin
          if (bus.send_ready) pkt_count_d = pkt_count_q + 1'b1;
          else                drop_pulse_d = 1'b1;
          timer_d = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_id_q   <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      pkt_count_q  <= '0;
      drop_pulse_q <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_id_q   <= grant_id_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      pkt_count_q  <= pkt_count_d;
      drop_pulse_q <= drop_pulse_d;
      timer_q      <= timer_d;
    end
  end

  // Accept pulse is combinational from req_valid, only while IDLE.
  assign bus.req_ready  = (state_q == IDLE) ? arb_grant : '0;
  assign bus.send_valid = (state_q == SEND);
  assign bus.send_addr  = addr_q;
  assign bus.send_data  = data_q;
  assign grant_id       = grant_id_q;
  assign drop_pulse     = drop_pulse_q;
  assign pkt_count      = pkt_count_q;

endmodule
